// File: rtl/blinds_position_ctrl_pkg.sv
// Shared definitions for the roller-blind position controller and the
// downstream selector that decodes {a, b}.
package blinds_pkg;

    typedef logic [1:0] pos_t;

    localparam pos_t POS_CLOSED  = 2'b00;
    localparam pos_t POS_QUARTER = 2'b01;
    localparam pos_t POS_HALF    = 2'b10;
    localparam pos_t POS_FULL    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2
    } state_t;

    // Saturating target adjust; simultaneous up/down events cancel out.
    function automatic pos_t target_update(pos_t cur, logic up, logic down);
        pos_t nxt;
        nxt = cur;
        if (up && !down && cur != POS_FULL) begin
            nxt = cur + 2'd1;
        end else if (down && !up && cur != POS_CLOSED) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/blinds_position_ctrl_if.sv
// Button inputs and selector/status outputs of the blind controller.
interface blinds_position_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic a;
    logic b;
    logic moving;
    logic dir_up;
    logic at_target;

    modport master (
        output btn_up, btn_down,
        input  a, b, moving, dir_up, at_target
    );

    modport slave (
        input  btn_up, btn_down,
        output a, b, moving, dir_up, at_target
    );
endinterface

// File: rtl/blinds_position_ctrl_btn_edge.sv
// Rising-edge detector for one button level. History resets to 0, so a
// button already held at reset release yields a single event.
module blinds_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/blinds_position_ctrl.sv
// Steps the blind position one level at a time toward a button-set target,
// each step lasting TRAVEL_CYCLES clocks. Position drives {a, b} directly.
module blinds_position_ctrl
    import blinds_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    blinds_position_ctrl_if.slave  bus
);
    localparam int CW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TRAVEL_CYCLES - 1);

    state_t        state, state_nx;
    pos_t          pos, pos_nx;
    pos_t          target, target_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          dir_up, dir_up_nx;
    logic          up_evt, down_evt;
    pos_t          pos_inc, pos_dec;

    blinds_btn_edge u_edge_up (
        .clk   (clk),
        .rst   (rst),
        .level (bus.btn_up),
        .rise  (up_evt)
    );

    blinds_btn_edge u_edge_down (
        .clk   (clk),
        .rst   (rst),
        .level (bus.btn_down),
        .rise  (down_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pos    <= POS_CLOSED;
            target <= POS_CLOSED;
            cnt    <= '0;
            dir_up <= 1'b0;
        end else begin
            state  <= state_nx;
            pos    <= pos_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
            dir_up <= dir_up_nx;
        end
    end

    assign pos_inc = pos + 2'd1;
    assign pos_dec = pos - 2'd1;

    always_comb begin
        state_nx  = state;
        pos_nx    = pos;
        cnt_nx    = cnt;
        dir_up_nx = dir_up;
        target_nx = target_update(target, up_evt, down_evt);

        // Decisions use the registered target; a same-cycle event is seen next cycle.
        case (state)
            ST_IDLE: begin
                if (target > pos) begin
                    state_nx  = ST_MOVE_UP;
                    cnt_nx    = RELOAD;
                    dir_up_nx = 1'b1;
                end else if (target < pos) begin
                    state_nx  = ST_MOVE_DOWN;
                    cnt_nx    = RELOAD;
                    dir_up_nx = 1'b0;
                end
            end
            ST_MOVE_UP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    pos_nx = pos_inc;
                    if (target > pos_inc) begin
                        cnt_nx = RELOAD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    pos_nx = pos_dec;
                    if (target < pos_dec) begin
                        cnt_nx = RELOAD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.a         = pos[1];
    assign bus.b         = pos[0];
    assign bus.moving    = (state != ST_IDLE);
    assign bus.dir_up    = dir_up;
    assign bus.at_target = (pos == target) && (state == ST_IDLE);
endmodule

// File: tb/tb_blinds_position_ctrl.sv
// Directed bench for blinds_position_ctrl (TRAVEL_CYCLES = 4); expectations are
// queued with the edge they fall due on and checked just after that edge.
module tb_blinds_position_ctrl;

    localparam logic [4:0] M_POS = 5'b11000;
    localparam logic [4:0] M_MOV = 5'b00100;
    localparam logic [4:0] M_DIR = 5'b00010;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string      tag;
        int         at_edge;
        logic [4:0] exp;
        logic [4:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   e0;
    exp_t sb[$];

    blinds_position_ctrl_if bus();

    blinds_position_ctrl #(.TRAVEL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input int at, input logic [4:0] exp,
                        input logic [4:0] mask);
        exp_t e;
        e.tag = tag;
        e.at_edge = at;
        e.exp = exp;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t       e;
        logic [4:0] obs;
        while (sb.size() > 0 && sb[0].at_edge <= edge_cnt) begin
            e = sb.pop_front();
            obs = {bus.a, bus.b, bus.moving, bus.dir_up, bus.at_target};
            n_checks++;
            assert ((obs & e.mask) === (e.exp & e.mask)) else begin
                n_fail++;
                $error("FAIL %s: observed {a,b,moving,dir_up,at_target}=%b required %b (mask %b)",
                       e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
        check_due();
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        #2;
        push("reset_state", edge_cnt, 5'b00001, M_ALL);
        check_due();
        tick();
        tick();
        #3 rst = 1'b0;
        tick();
        push("post_reset_at_target", edge_cnt, 5'b00001, M_ALL);
        check_due();

        // single up step
        bus.btn_up = 1'b1;
        e0 = edge_cnt + 1;
        push("up_e0_idle", e0, 5'b00000, M_MOV);
        push("up_e1_moving", e0 + 1, 5'b00110, M_MOV | M_DIR);
        push("up_e4_still_00", e0 + 4, 5'b00100, M_POS | M_MOV);
        push("up_e5_pos01", e0 + 5, 5'b01011, M_ALL);
        tick();
        bus.btn_up = 1'b0;
        repeat (6) tick();

        // held button gives exactly one step
        bus.btn_up = 1'b1;
        e0 = edge_cnt + 1;
        push("hold_e5_pos10", e0 + 5, 5'b10011, M_ALL);
        push("hold_e20_pos10", e0 + 20, 5'b10011, M_ALL);
        repeat (21) tick();
        bus.btn_up = 1'b0;
        tick();

        // repeated up pulses saturate at full
        e0 = edge_cnt + 1;
        push("sat_e5_pos11", e0 + 5, 5'b11011, M_ALL);
        push("sat_e12_pos11", e0 + 12, 5'b11011, M_ALL);
        push("sat_e30_pos11", e0 + 30, 5'b11011, M_ALL);
        for (int i = 0; i < 7; i++) begin
            bus.btn_up = 1'b1;
            tick();
            bus.btn_up = 1'b0;
            tick();
        end
        repeat (20) tick();

        // one down pulse must land on half, proving target held at 3
        bus.btn_down = 1'b1;
        e0 = edge_cnt + 1;
        push("sat_down_e1_moving", e0 + 1, 5'b00100, M_MOV | M_DIR);
        push("sat_down_e5_pos10", e0 + 5, 5'b10001, M_ALL);
        tick();
        bus.btn_down = 1'b0;
        repeat (6) tick();

        // asynchronous reset in the middle of a step
        bus.btn_down = 1'b1;
        tick();
        bus.btn_down = 1'b0;
        tick();
        tick();
        push("rst_pre_moving", edge_cnt, 5'b00100, M_MOV);
        check_due();
        #3 rst = 1'b1;
        #1;
        push("rst_async_clear", edge_cnt, 5'b00001, M_ALL);
        check_due();
        tick();
        #3 rst = 1'b0;
        tick();
        push("rst_release", edge_cnt, 5'b00001, M_ALL);
        push("rst_quiet", edge_cnt + 6, 5'b00001, M_ALL);
        check_due();
        repeat (6) tick();

        // multi-step up, then a reversal queued during the second step
        e0 = edge_cnt + 1;
        push("ms_e1_moving_up", e0 + 1, 5'b00110, M_MOV | M_DIR);
        push("ms_e5_pos01_moving", e0 + 5, 5'b01110, M_POS | M_MOV | M_DIR);
        push("ms_e7_pos01_moving", e0 + 7, 5'b01100, M_POS | M_MOV);
        push("ms_e9_pos10_idle", e0 + 9, 5'b10010, M_ALL);
        push("ms_e10_moving_down", e0 + 10, 5'b10100, M_ALL);
        push("ms_e13_still_10", e0 + 13, 5'b10100, M_ALL);
        push("ms_e14_pos01", e0 + 14, 5'b01001, M_ALL);
        bus.btn_up = 1'b1;
        tick();
        bus.btn_up = 1'b0;
        tick();
        bus.btn_up = 1'b1;
        tick();
        bus.btn_up = 1'b0;
        repeat (3) tick();
        bus.btn_down = 1'b1;
        tick();
        bus.btn_down = 1'b0;
        repeat (10) tick();

        // simultaneous up and down events are ignored
        bus.btn_up = 1'b1;
        bus.btn_down = 1'b1;
        e0 = edge_cnt + 1;
        push("sim_e1_no_motion", e0 + 1, 5'b01001, M_ALL);
        push("sim_e6_no_motion", e0 + 6, 5'b01001, M_ALL);
        tick();
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        repeat (6) tick();

        // step down to closed
        bus.btn_down = 1'b1;
        e0 = edge_cnt + 1;
        push("dn_e5_pos00", e0 + 5, 5'b00001, M_ALL);
        tick();
        bus.btn_down = 1'b0;
        repeat (6) tick();

        // down at closed does nothing
        bus.btn_down = 1'b1;
        e0 = edge_cnt + 1;
        push("bnd_e1_no_motion", e0 + 1, 5'b00001, M_ALL);
        push("bnd_e6_no_motion", e0 + 6, 5'b00001, M_ALL);
        tick();
        bus.btn_down = 1'b0;
        repeat (6) tick();

        // next up pulse moves exactly one level, so target did not wrap
        bus.btn_up = 1'b1;
        e0 = edge_cnt + 1;
        push("bnd_up_e4_moving", e0 + 4, 5'b00110, M_ALL);
        push("bnd_up_e5_pos01", e0 + 5, 5'b01011, M_ALL);
        push("bnd_up_e12_pos01", e0 + 12, 5'b01011, M_ALL);
        tick();
        bus.btn_up = 1'b0;
        repeat (13) tick();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: observed not reached by edge %0d, required check at edge %0d",
                     e.tag, edge_cnt, e.at_edge);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
